// File: rtl/store_merge_unit_pkg.sv
// Shared types for the store merge unit: size codes, FSM states, default read latency.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    DONE,
    ERR
  } state_e;

  localparam int MEM_RD_LAT_DEFAULT = 1;

endpackage

// File: rtl/store_merge_unit_if.sv
// Request handshake and memory write-port bundle between the control FSM, the store unit and memory.
interface store_merge_unit_if;

  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, size, addr, wdata, mem_rdata,
    input  mem_addr, mem_wdata, mem_wr, busy, done, err
  );

  modport slave (
    input  start, size, addr, wdata, mem_rdata,
    output mem_addr, mem_wdata, mem_wr, busy, done, err
  );

endinterface

// File: rtl/store_merge_unit_merge.sv
// Combinational little-endian lane merge: inserts the store byte/half into the old word.
module byte_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    case (size_i)
      SZ_WORD: merged_o = wdata_i;
      SZ_HALF: merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      SZ_BYTE: merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      default: merged_o = old_i;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// Read-modify-write store engine for sw/sh/sb into word-addressed memory.
// Optional build macro STORE_ALIGN_TRAP_EN turns misaligned sh/sw into an err pulse.
module store_merge_unit
  import store_pkg::*;
#(
  parameter int MEM_RD_LAT = MEM_RD_LAT_DEFAULT
) (
  input logic               clk,
  input logic               reset,
  store_merge_unit_if.slave bus
);

  localparam logic [2:0] LAT_LAST = 3'(MEM_RD_LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  lat_q, lat_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] old_q, old_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_wr_q, mem_wr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] merged;
  logic        trap;

`ifdef STORE_ALIGN_TRAP_EN
  assign trap = ((bus.size == SZ_HALF) && bus.addr[0]) ||
                ((bus.size == SZ_WORD) && (bus.addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  byte_lane_merge u_merge (
    .old_i    (old_q),
    .wdata_i  (wdata_q),
    .size_i   (size_q),
    .lane_i   (addr_q[1:0]),
    .merged_o (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      old_q       <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      old_q       <= old_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Request fields are captured only when a start is accepted in IDLE.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    case (state_q)
      IDLE: begin
        lat_d = '0;
        if (bus.start) begin
          addr_d  = bus.addr;
          size_d  = bus.size;
          wdata_d = bus.wdata;
          if ((bus.size == SZ_RSVD) || trap) state_d = ERR;
          else if (bus.size == SZ_WORD)      state_d = WRITE;
          else                               state_d = READ;
        end
      end
      READ: begin
        if (lat_q == LAT_LAST) begin
          old_d   = bus.mem_rdata;
          lat_d   = '0;
          state_d = WRITE;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered so they appear one cycle after their state.
  always_comb begin
    mem_wr_d    = (state_q == WRITE);
    done_d      = (state_q == DONE);
    err_d       = (state_q == ERR);
    mem_wdata_d = (state_q == WRITE) ? merged : mem_wdata_q;
  end

  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
